execute_stage_md: RTL and testbench

- Parametrised, pipelined successor to the single-cycle execute datapath.
- Takes decoded ID/EX operands through a valid/ready handshake and applies MEM/WB operand forwarding.
- Runs single-cycle ALU ops or iterative RV-M multiply/divide ops, then holds the result in a registered EX/MEM output slot.
- The register file, decode/immediate generation and the data memory stay outside the block.

---
 rtl/execute_stage_md_if.sv | 50 +++++
 rtl/execute_stage_md.sv | 181 ++++++++++++++++++
 tb/tb_execute_stage_md.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_md_if.sv
// Purpose: ID/EX input bus and EX/MEM output slot of execute_stage_md, including both handshakes.
// Ports: slave = execute stage view (consumes in_*, fwd_*, out_ready); master = the opposite side.
// Backpressure: in_valid/in_ready on the input side and out_valid/out_ready on the output slot.
interface execute_stage_md_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_alu_ctrl;
    logic            in_is_md;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic [XLEN-1:0] in_imm;
    logic            in_alu_src;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [XLEN-1:0] mem_fwd_data;
    logic [XLEN-1:0] wb_fwd_data;
    logic [4:0]      in_rd;
    logic            in_we;
    logic            in_mem_read;
    logic            in_mem_write;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd;
    logic            out_we;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            busy;

    modport slave (
        input  in_valid, in_alu_ctrl, in_is_md, in_funct3, in_rs1_val, in_rs2_val, in_imm,
               in_alu_src, fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data, in_rd, in_we,
               in_mem_read, in_mem_write, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_store_data, out_rd, out_we,
               out_mem_read, out_mem_write, busy
    );

    modport master (
        output in_valid, in_alu_ctrl, in_is_md, in_funct3, in_rs1_val, in_rs2_val, in_imm,
               in_alu_src, fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data, in_rd, in_we,
               in_mem_read, in_mem_write, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_store_data, out_rd, out_we,
               out_mem_read, out_mem_write, busy
    );
endinterface

// File: rtl/execute_stage_md.sv
// Purpose: execute stage with MEM/WB forwarding, 1-cycle ALU and iterative RV-M mul/div into a registered slot.
// Latency: ALU 1 cycle (1 op/cycle); M ops XLEN+2 cycles, input blocked while busy.
// Backpressure: the slot holds while out_ready=0; in_ready drops until it drains. Ports: clk, rst_n, flush, io (slave).
module execute_stage_md #(
    parameter int XLEN  = 32,
    parameter int MD_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    execute_stage_md_if.slave    io
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    // acc_hi/acc_lo: {partial product, multiplier} for mul, {remainder, quotient} for div
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   md_b;
    logic [2:0]        md_f3;
    logic              neg_a;
    logic              neg_b;
    logic              div_zero;

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
        case (sel)
            2'b01:   return mem;
            2'b10:   return wb;
            default: return rf;
        endcase
    endfunction

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, alu_out;
    logic            accept, md_op;

    assign op_a  = fwd_mux(io.fwd_a_sel, io.in_rs1_val, io.mem_fwd_data, io.wb_fwd_data);
    assign fwd_b = fwd_mux(io.fwd_b_sel, io.in_rs2_val, io.mem_fwd_data, io.wb_fwd_data);
    assign op_b  = io.in_alu_src ? io.in_imm : fwd_b;

    assign io.in_ready = (state == ST_IDLE) && (!io.out_valid || io.out_ready);
    assign io.busy     = (state != ST_IDLE);
    assign accept      = io.in_valid && io.in_ready && !flush;
    assign md_op       = io.in_is_md && (MD_EN != 0);

    always_comb begin
        alu_res = '0;
        case (io.in_alu_ctrl)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'b1001: alu_res = op_a ^ op_b;
            4'b1010: alu_res = op_a << op_b[SHW-1:0];
            4'b1011: alu_res = op_a >> op_b[SHW-1:0];
            4'b1100: alu_res = $signed(op_a) >>> op_b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // An M op that reaches here with the unit absent completes immediately with 0
    assign alu_out = io.in_is_md ? '0 : alu_res;

    // Operand signedness: DIV/REM (f3[0]=0) signed; MULH signs both, MULHSU only A; MUL is sign-agnostic
    logic            a_sgn, b_sgn, na, nb;
    logic [XLEN-1:0] abs_a, abs_b;
    assign a_sgn = io.in_funct3[2] ? !io.in_funct3[0] : (io.in_funct3[1:0] == 2'b01 || io.in_funct3[1:0] == 2'b10);
    assign b_sgn = io.in_funct3[2] ? !io.in_funct3[0] : (io.in_funct3[1:0] == 2'b01);
    assign na    = a_sgn && op_a[XLEN-1];
    assign nb    = b_sgn && op_b[XLEN-1];
    assign abs_a = na ? -op_a : op_a;
    assign abs_b = nb ? -op_b : op_b;

    // One iteration: shift-add for multiply, restoring subtract for divide
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_b} : '0);
    assign rem_sh   = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff = rem_sh - {1'b0, md_b};

    // Sign correction on the magnitude results
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, md_res;
    assign prod = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    assign rem  = neg_a ? -acc_hi : acc_hi;

    always_comb begin
        md_res = '0;
        case (md_f3)
            3'b000:                 md_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_res = div_zero ? '1 : quo;
            default:                md_res = rem;  // remainder of x/0 is x via the same path
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            acc_hi            <= '0;
            acc_lo            <= '0;
            md_b              <= '0;
            md_f3             <= '0;
            neg_a             <= 1'b0;
            neg_b             <= 1'b0;
            div_zero          <= 1'b0;
            io.out_valid      <= 1'b0;
            io.out_result     <= '0;
            io.out_zero       <= 1'b0;
            io.out_store_data <= '0;
            io.out_rd         <= '0;
            io.out_we         <= 1'b0;
            io.out_mem_read   <= 1'b0;
            io.out_mem_write  <= 1'b0;
        end else if (flush) begin
            state        <= ST_IDLE;
            io.out_valid <= 1'b0;
        end else begin
            if (io.out_valid && io.out_ready) io.out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // Accept implies the slot is empty or draining now, so control can land directly
                        io.out_store_data <= fwd_b;
                        io.out_rd         <= io.in_rd;
                        io.out_we         <= io.in_we;
                        io.out_mem_read   <= io.in_mem_read;
                        io.out_mem_write  <= io.in_mem_write;
                        if (md_op) begin
                            state    <= ST_RUN;
                            cnt      <= CW'(XLEN);
                            acc_hi   <= '0;
                            acc_lo   <= abs_a;
                            md_b     <= abs_b;
                            md_f3    <= io.in_funct3;
                            neg_a    <= na;
                            neg_b    <= nb;
                            div_zero <= (op_b == '0);
                        end else begin
                            io.out_valid  <= 1'b1;
                            io.out_result <= alu_out;
                            io.out_zero   <= (alu_out == '0);
                        end
                    end
                end
                ST_RUN: begin
                    if (md_f3[2]) begin
                        if (!div_diff[XLEN]) begin
                            acc_hi <= div_diff[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi <= rem_sh[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    io.out_valid  <= 1'b1;
                    io.out_result <= md_res;
                    io.out_zero   <= (md_res == '0);
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;
    localparam int XLEN  = 32;
    localparam int MDLAT = XLEN + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    execute_stage_md_if #(.XLEN(XLEN)) io();
    execute_stage_md #(.XLEN(XLEN), .MD_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (io.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] mem, input logic [31:0] wb);
        if (sel == 2'b01) return mem;
        if (sel == 2'b10) return wb;
        return rf;
    endfunction

    function automatic logic [31:0] model(input logic [3:0] ctrl, input logic is_md,
                                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (is_md) begin
            ea = {32'b0, a};
            eb = {32'b0, b};
            if (f3 == 3'd1 || f3 == 3'd2) ea = {{32{a[31]}}, a};
            if (f3 == 3'd1) eb = {{32{b[31]}}, b};
            p = ea * eb;
            case (f3)
                3'd0:       return p[31:0];
                3'd1, 3'd2, 3'd3: return p[63:32];
                3'd4:       return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
                3'd5:       return (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6:       return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
                default:    return (b == 0) ? a : a % b;
            endcase
        end
        case (ctrl)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:    return (a < b) ? 32'd1 : 32'd0;
            4'd9:    return a ^ b;
            4'd10:   return a << b[4:0];
            4'd11:   return a >> b[4:0];
            4'd12:   return 32'(sa >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we, mr, mw;
        logic [31:0] sd;
        int          due;
    } exp_t;
    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          cyc;
    } log_t;

    exp_t q[$];
    log_t lg[$];
    bit   mon_en = 1'b0;
    bit   md_act = 1'b0;
    int   md_due = 0;
    logic ev, eb, er;
    exp_t e;
    logic [31:0] fa_v, fb_v;

    // Per-cycle compare: outputs checked, then this cycle's handshakes applied to the model
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            md_act = 1'b0;
        end else if (mon_en) begin
            if (md_act && cyc >= md_due) md_act = 1'b0;
            ev = (q.size() > 0) && (q[0].due <= cyc);
            eb = md_act;
            er = !eb && (!ev || io.out_ready);
            chk("out_valid", io.out_valid, ev);
            chk("busy", io.busy, eb);
            chk("in_ready", io.in_ready, er);
            if (ev && io.out_valid) begin
                chk("out_result", io.out_result, q[0].res);
                chk("out_zero", io.out_zero, q[0].res == 32'd0);
                chk("out_rd", io.out_rd, q[0].rd);
                chk("out_we", io.out_we, q[0].we);
                chk("out_mem_read", io.out_mem_read, q[0].mr);
                chk("out_mem_write", io.out_mem_write, q[0].mw);
                chk("out_store_data", io.out_store_data, q[0].sd);
            end
            if (ev && io.out_ready) begin
                lg.push_back('{res: io.out_result, zero: io.out_zero, cyc: cyc});
                void'(q.pop_front());
            end
            if (flush) begin
                q.delete();
                md_act = 1'b0;
            end else if (io.in_valid && er) begin
                fa_v  = fwd(io.fwd_a_sel, io.in_rs1_val, io.mem_fwd_data, io.wb_fwd_data);
                fb_v  = fwd(io.fwd_b_sel, io.in_rs2_val, io.mem_fwd_data, io.wb_fwd_data);
                e.res = model(io.in_alu_ctrl, io.in_is_md, io.in_funct3, fa_v,
                              io.in_alu_src ? io.in_imm : fb_v);
                e.rd  = io.in_rd;
                e.we  = io.in_we;
                e.mr  = io.in_mem_read;
                e.mw  = io.in_mem_write;
                e.sd  = fb_v;
                e.due = cyc + (io.in_is_md ? MDLAT : 1);
                q.push_back(e);
                if (io.in_is_md) begin
                    md_act = 1'b1;
                    md_due = e.due;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int seq = 1;
    int acc_cyc = 0;

    task automatic send(input logic [3:0] ctrl, input logic md, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic src, input logic [1:0] fa, input logic [1:0] fb);
        bit done;
        done = 1'b0;
        io.in_alu_ctrl  = ctrl;
        io.in_is_md     = md;
        io.in_funct3    = f3;
        io.in_rs1_val   = a;
        io.in_rs2_val   = b;
        io.in_imm       = imm;
        io.in_alu_src   = src;
        io.fwd_a_sel    = fa;
        io.fwd_b_sel    = fb;
        io.in_rd        = 5'(seq);
        io.in_we        = (seq % 2) == 1;
        io.in_mem_read  = (seq % 3) == 0;
        io.in_mem_write = (seq % 5) == 0;
        seq++;
        io.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (io.in_ready && !flush) begin
                acc_cyc = cyc;
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
        end
        @(posedge clk); #1;
    endtask

    // Drop valid and scramble inputs: captured ops must not see these
    task automatic idle();
        io.in_valid     = 1'b0;
        io.in_rs1_val   = $urandom();
        io.in_rs2_val   = $urandom();
        io.in_imm       = $urandom();
        io.mem_fwd_data = $urandom();
        io.wb_fwd_data  = $urandom();
        io.fwd_a_sel    = 2'($urandom_range(0, 3));
        io.in_funct3    = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_log(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (lg.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_log: got %0d results, expected %0d", lg.size(), n);
        end
    endtask

    logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd3, 4'd7, 4'd6};
    int a0, a1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        io.in_valid = 1'b0; io.out_ready = 1'b1;
        io.in_alu_ctrl = '0; io.in_is_md = 1'b0; io.in_funct3 = '0;
        io.in_rs1_val = '0; io.in_rs2_val = '0; io.in_imm = '0; io.in_alu_src = 1'b0;
        io.fwd_a_sel = '0; io.fwd_b_sel = '0; io.mem_fwd_data = 32'd7; io.wb_fwd_data = 32'd4;
        io.in_rd = '0; io.in_we = 1'b0; io.in_mem_read = 1'b0; io.in_mem_write = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_out_result", io.out_result, 0);
        chk("rst_busy", io.busy, 0);
        chk("rst_out_rd", io.out_rd, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", io.in_ready, 1);
        mon_en = 1'b1;

        // ADD 5 + imm(-3)
        lg.delete();
        send(4'd2, 0, 0, 32'd5, 32'd0, 32'hFFFF_FFFD, 1, 2'b00, 2'b00);
        a0 = acc_cyc;
        idle();
        wait_log(1);
        chk("add_result", lg[0].res, 32'd2);
        chk("add_zero", lg[0].zero, 0);
        chk("add_latency", lg[0].cyc - a0, 1);

        // Back-to-back ADD, SUB with A forwarded from MEM
        lg.delete();
        io.mem_fwd_data = 32'd7;
        send(4'd2, 0, 0, 32'd99, 32'd7, 32'd0, 0, 2'b01, 2'b00);
        send(4'd6, 0, 0, 32'd99, 32'd7, 32'd0, 0, 2'b01, 2'b00);
        idle();
        wait_log(2);
        chk("b2b_add", lg[0].res, 32'd14);
        chk("b2b_sub", lg[1].res, 32'd0);
        chk("b2b_sub_zero", lg[1].zero, 1);
        chk("b2b_spacing", lg[1].cyc - lg[0].cyc, 1);

        // MUL then MULHU on 0xFFFFFFFF x 2
        lg.delete();
        send(4'd0, 1, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 2'b00, 2'b00);
        a0 = acc_cyc;
        send(4'd0, 1, 3'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 2'b00, 2'b00);
        a1 = acc_cyc;
        idle();
        @(negedge clk);
        chk("mul_busy", io.busy, 1);
        chk("mul_in_ready", io.in_ready, 0);
        wait_log(2);
        chk("mul_result", lg[0].res, 32'hFFFF_FFFE);
        chk("mul_latency", lg[0].cyc - a0, MDLAT);
        chk("mulhu_result", lg[1].res, 32'h0000_0001);
        chk("mulhu_latency", lg[1].cyc - a1, MDLAT);

        // Division corner cases plus signed variants
        lg.delete();
        send(4'd0, 1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 2'b00, 2'b00);
        send(4'd0, 1, 3'd5, 32'd10, 32'd0, 32'd0, 0, 2'b00, 2'b00);
        send(4'd0, 1, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 2'b00, 2'b00);
        send(4'd0, 1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 2'b00, 2'b00);
        send(4'd0, 1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 2'b00, 2'b00);
        send(4'd0, 1, 3'd4, 32'hFFFF_FFF9, 32'd0, 32'd0, 0, 2'b00, 2'b00);
        send(4'd0, 1, 3'd1, 32'hFFFF_FFFD, 32'd5, 32'd0, 0, 2'b00, 2'b00);
        send(4'd0, 1, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 2'b00, 2'b00);
        idle();
        wait_log(8);
        chk("div_ovf", lg[0].res, 32'h8000_0000);
        chk("divu_by0", lg[1].res, 32'hFFFF_FFFF);
        chk("rem_neg", lg[2].res, 32'hFFFF_FFFF);
        chk("div_neg", lg[3].res, 32'hFFFF_FFFD);
        chk("rem_ovf", lg[4].res, 32'h0);
        chk("div_neg_by0", lg[5].res, 32'hFFFF_FFFF);

        // ALU table, B forwarded from WB
        lg.delete();
        io.wb_fwd_data = 32'd4;
        for (int i = 0; i < 10; i++) send(ops[i], 0, 0, 32'h8000_0F0F, 32'd0, 32'd0, 0, 2'b00, 2'b10);
        idle();
        wait_log(10);
        chk("sltu", lg[2].res, 32'd0);
        chk("sll", lg[4].res, 32'h0000_F0F0);
        chk("sra", lg[6].res, 32'hF800_00F0);
        chk("bad_code", lg[7].res, 32'd0);

        // Slot hold under backpressure, then drain + accept in one cycle
        lg.delete();
        io.out_ready = 1'b0;
        send(4'd7, 0, 0, 32'hFFFF_FFFF, 32'd0, 32'd1, 1, 2'b00, 2'b00);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", io.out_result, 32'd1);
            chk("hold_in_ready", io.in_ready, 0);
        end
        @(posedge clk); #1;
        io.out_ready = 1'b1;
        send(4'd9, 0, 0, 32'h0000_00F0, 32'h0000_00FF, 32'd0, 0, 2'b00, 2'b00);
        idle();
        wait_log(2);
        chk("hold_slt", lg[0].res, 32'd1);
        chk("drain_accept_same", lg[0].cyc - acc_cyc, 0);
        chk("xor_result", lg[1].res, 32'h0000_000F);
        chk("xor_no_bubble", lg[1].cyc - acc_cyc, 1);

        // Flush at cycle 10 of a DIVU
        lg.delete();
        send(4'd0, 1, 3'd5, 32'd100, 32'd7, 32'd0, 0, 2'b00, 2'b00);
        idle();
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", io.busy, 0);
        chk("flush_out_valid", io.out_valid, 0);
        chk("flush_in_ready", io.in_ready, 1);
        // An op offered in the flush cycle must be ignored
        @(posedge clk); #1;
        flush = 1'b1;
        io.in_valid = 1'b1; io.in_is_md = 1'b0; io.in_alu_ctrl = 4'd2;
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_no_accept", io.out_valid, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_result", lg.size(), 0);

        // Asynchronous reset in the middle of a MUL
        send(4'd0, 1, 3'd0, 32'd3, 32'd4, 32'd0, 0, 2'b00, 2'b00);
        idle();
        repeat (5) @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", io.busy, 0);
        chk("arst_out_valid", io.out_valid, 0);
        chk("arst_out_rd", io.out_rd, 0);
        chk("arst_out_we", io.out_we, 0);
        chk("arst_out_mem", {io.out_mem_read, io.out_mem_write}, 0);
        chk("arst_store_data", io.out_store_data, 0);
        chk("arst_result", {io.out_result, io.out_zero}, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        lg.delete();
        send(4'd1, 0, 0, 32'h0000_0F00, 32'h0000_00F0, 32'd0, 0, 2'b00, 2'b00);
        idle();
        wait_log(1);
        chk("post_rst_or", lg[0].res, 32'h0000_0FF0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
